// File: rtl/regbank_port_sequencer.sv
// rtl/regbank_port_sequencer.sv - sequences writebacks and two-operand reads onto a single-port register bank
module regbank_port_sequencer #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [SEL_W-1:0]  rs1,
    input  logic [SEL_W-1:0]  rs2,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [SEL_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [SEL_W-1:0]  bank_select,
    output logic              bank_write,
    output logic [DATA_W-1:0] bank_dataIn,
    input  logic [DATA_W-1:0] bank_dataOut
);

    typedef enum logic [2:0] {IDLE, WRITE, READ1, READ2, RESP} state_t;

    state_t             state, state_nxt;
    logic               wb_full, req_pending;
    logic [SEL_W-1:0]   wb_rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic               wb_fire, req_fire, rsp_fire;
    logic [SEL_W-1:0]   wb_rd_nxt, rs1_nxt;
    logic [DATA_W-1:0]  wb_data_nxt;

    // Readies are gated by reset so they read 0 while held and 1 right after release.
    assign wb_ready     = reset && !wb_full;
    assign rd_req_ready = reset && (state == IDLE) && !req_pending;

    assign wb_fire  = wb_valid && wb_ready;
    assign req_fire = rd_req_valid && rd_req_ready;
    assign rsp_fire = rd_rsp_valid && rd_rsp_ready;

    assign wb_rd_nxt   = wb_fire  ? wb_rd   : wb_rd_q;
    assign wb_data_nxt = wb_fire  ? wb_data : wb_data_q;
    assign rs1_nxt     = req_fire ? rs1     : rs1_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wb_full || wb_fire)
                    state_nxt = WRITE;
                else if (req_pending || req_fire)
                    state_nxt = READ1;
            end
            WRITE:   state_nxt = req_pending ? READ1 : IDLE;
            READ1:   state_nxt = READ2;
            READ2:   state_nxt = RESP;
            RESP: begin
                if (rsp_fire)
                    state_nxt = wb_full ? WRITE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wb_full      <= 1'b0;
            req_pending  <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data     <= '0;
            rs2_data     <= '0;
            rd_rsp_valid <= 1'b0;
            bank_select  <= '0;
            bank_write   <= 1'b0;
            bank_dataIn  <= '0;
        end else begin
            state <= state_nxt;

            if (wb_fire) begin
                wb_rd_q   <= wb_rd;
                wb_data_q <= wb_data;
            end
            if (state == WRITE)
                wb_full <= 1'b0;
            else if (wb_fire)
                wb_full <= 1'b1;

            if (req_fire) begin
                rs1_q       <= rs1;
                rs2_q       <= rs2;
                req_pending <= 1'b1;
            end else if (state == READ2) begin
                req_pending <= 1'b0;
            end

            // Register 0 is hardwired to zero on the read side.
            if (state == READ1)
                rs1_data <= (rs1_q == '0) ? '0 : bank_dataOut;
            if (state == READ2)
                rs2_data <= (rs2_q == '0) ? '0 : bank_dataOut;

            // Bank-facing outputs are registered from the upcoming state.
            rd_rsp_valid <= (state_nxt == RESP);
            bank_write   <= (state_nxt == WRITE) && (wb_rd_nxt != '0);
            bank_dataIn  <= (state_nxt == WRITE) ? wb_data_nxt : '0;
            case (state_nxt)
                WRITE:   bank_select <= wb_rd_nxt;
                READ1:   bank_select <= rs1_nxt;
                READ2:   bank_select <= rs2_q;
                default: bank_select <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_port_sequencer.sv
// tb/tb_regbank_port_sequencer.sv - schedule-based reference model bench for regbank_port_sequencer
module tb_regbank_port_sequencer;

    localparam int DW = 32;
    localparam int SW = 4;
    localparam int OP_IDLE = 0, OP_W = 1, OP_R1 = 2, OP_R2 = 3, OP_RSP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req_valid, rd_req_ready;
    logic [SW-1:0] rs1, rs2;
    logic          rd_rsp_valid, rd_rsp_ready;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          wb_valid, wb_ready;
    logic [SW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [SW-1:0] bank_select;
    logic          bank_write;
    logic [DW-1:0] bank_dataIn, bank_dataOut;

    regbank_port_sequencer #(.DATA_W(DW), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rs1(rs1), .rs2(rs2),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .bank_select(bank_select), .bank_write(bank_write),
        .bank_dataIn(bank_dataIn), .bank_dataOut(bank_dataOut)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int i);
        return 32'h1000_0000 + i * 32'h0101;
    endfunction

    // Environment: the single-port bank, reloaded with a known pattern while reset is low
    logic [DW-1:0] bank [16];
    int            n_writes = 0;
    assign bank_dataOut = bank[bank_select];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) bank[i] <= init_val(i);
        end else if (bank_write) begin
            bank[bank_select] <= bank_dataIn;
            n_writes++;
        end
    end

    // Reference model: a schedule of pending bank operations plus architectural register contents
    int            plan[$];
    logic [DW-1:0] refmem [16];
    logic          m_full;
    logic [SW-1:0] m_rd, m_rs1, m_rs2;
    logic [DW-1:0] m_data, m_d1, m_d2;

    int passed = 0, total = 0;
    logic last_rsp_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic model_clear();
        plan.delete();
        m_full = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_data = 0; m_d1 = 0; m_d2 = 0;
        for (int i = 0; i < 16; i++) refmem[i] = init_val(i);
    endtask

    function automatic int cur_op();
        return (plan.size() != 0) ? plan[0] : OP_IDLE;
    endfunction

    task automatic compare_and_step();
        int            op;
        logic          e_rq, e_wb, e_rsp, wbf, rqf;
        logic [SW-1:0] e_sel;
        op    = cur_op();
        e_rq  = (op == OP_IDLE);
        e_wb  = !m_full;
        e_rsp = (op == OP_RSP);
        e_sel = (op == OP_W) ? m_rd : (op == OP_R1) ? m_rs1 : (op == OP_R2) ? m_rs2 : '0;
        chk("rd_req_ready", rd_req_ready, e_rq);
        chk("wb_ready", wb_ready, e_wb);
        chk("rd_rsp_valid", rd_rsp_valid, e_rsp);
        chk("bank_select", bank_select, e_sel);
        chk("bank_write", bank_write, (op == OP_W) && (m_rd != 0));
        chk("bank_dataIn", bank_dataIn, (op == OP_W) ? m_data : '0);
        chk("rs1_data", rs1_data, m_d1);
        chk("rs2_data", rs2_data, m_d2);

        wbf = wb_valid && e_wb;
        rqf = rd_req_valid && e_rq;
        case (op)
            OP_IDLE: begin
                if (wbf || m_full) plan.push_back(OP_W);
                if (rqf) begin plan.push_back(OP_R1); plan.push_back(OP_R2); plan.push_back(OP_RSP); end
            end
            OP_W: begin
                if (m_rd != 0) refmem[m_rd] = m_data;
                m_full = 0;
                void'(plan.pop_front());
            end
            OP_R1: begin m_d1 = (m_rs1 == 0) ? '0 : refmem[m_rs1]; void'(plan.pop_front()); end
            OP_R2: begin m_d2 = (m_rs2 == 0) ? '0 : refmem[m_rs2]; void'(plan.pop_front()); end
            default: begin
                if (rd_rsp_ready) begin
                    void'(plan.pop_front());
                    if (m_full) plan.push_back(OP_W);
                end
            end
        endcase
        if (wbf) begin m_rd = wb_rd; m_data = wb_data; m_full = 1; end
        if (rqf) begin m_rs1 = rs1; m_rs2 = rs2; end
    endtask

    // One clock: inputs already set by the caller, compare mid-cycle, return just after the edge
    task automatic tick();
        @(negedge clk);
        last_rsp_valid = rd_rsp_valid;
        compare_and_step();
        @(posedge clk);
        #1;
    endtask

    // Request in IDLE (optionally with a same-cycle writeback), return once the response is seen
    task automatic req_wait(input logic do_wb, input logic [SW-1:0] wrd, input logic [DW-1:0] wdat,
                            input logic [SW-1:0] a, input logic [SW-1:0] b, input int exp_lat,
                            input string name);
        int k;
        rd_rsp_ready = 0;
        rd_req_valid = 1; rs1 = a; rs2 = b;
        wb_valid = do_wb; wb_rd = wrd; wb_data = wdat;
        tick();
        rd_req_valid = 0; wb_valid = 0;
        k = 1;
        while (k <= 10) begin
            tick();
            if (last_rsp_valid) break;
            k++;
        end
        chk(name, k, exp_lat);
    endtask

    task automatic release_rsp();
        rd_rsp_ready = 1;
        tick();
        rd_rsp_ready = 0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_outs"}, {rd_req_ready, wb_ready, rd_rsp_valid, bank_write, bank_select}, '0);
        chk({name, "_data"}, {rs1_data, rs2_data}, '0);
        chk({name, "_din"}, bank_dataIn, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset = 0;
        rd_req_valid = 0; rs1 = 0; rs2 = 0; rd_rsp_ready = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_hold");
        reset = 1;
        #1;
        chk("post_reset_req_ready", rd_req_ready, 1);
        chk("post_reset_wb_ready", wb_ready, 1);

        // Writeback then read it back alongside register 0
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        tick();
        wb_valid = 0;
        tick();
        req_wait(0, 0, 0, 5, 0, 3, "lat_plain");
        chk("t034_rs1", rs1_data, 32'hDEADBEEF);
        chk("t034_rs2", rs2_data, 32'h0);
        release_rsp();
        tick();

        // Same-cycle writeback and request: write first, response one cycle later
        w0 = n_writes;
        req_wait(1, 3, 32'h12345678, 3, 3, 4, "lat_write_first");
        chk("t035_rs1", rs1_data, 32'h12345678);
        chk("t035_rs2", rs2_data, 32'h12345678);
        chk("t035_writes", n_writes - w0, 1);
        release_rsp();
        tick();

        // Writeback arriving during READ1 must not leak into the response
        rd_req_valid = 1; rs1 = 7; rs2 = 1;
        tick();
        rd_req_valid = 0;
        wb_valid = 1; wb_rd = 7; wb_data = 32'hAAAA5555;
        tick();
        wb_valid = 0;
        tick();
        tick();
        chk("t036_rsp_valid", last_rsp_valid, 1);
        chk("t036_rs1_old", rs1_data, 32'h1000_0707);
        chk("t036_rs2", rs2_data, 32'h1000_0101);
        release_rsp();
        chk("t036_bw", {bank_write, bank_select, bank_dataIn}, {1'b1, 4'd7, 32'hAAAA5555});
        tick();
        tick();

        // Stalled response with one buffered writeback
        rd_req_valid = 1; rs1 = 2; rs2 = 9;
        tick();
        rd_req_valid = 0;
        tick();
        tick();
        w0 = n_writes;
        wb_valid = 1; wb_rd = 4; wb_data = 32'h0BADF00D;
        tick();
        wb_valid = 0;
        chk("t037_wb_ready_low", wb_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t037_rsp_hold", last_rsp_valid, 1);
            chk("t037_rs1_hold", rs1_data, 32'h1000_0202);
            chk("t037_rs2_hold", rs2_data, 32'h1000_0909);
        end
        chk("t037_no_write", n_writes - w0, 0);
        release_rsp();
        chk("t037_bw", {bank_write, bank_select, bank_dataIn}, {1'b1, 4'd4, 32'h0BADF00D});
        tick();
        tick();

        // Writeback to register 0 completes with no bank write; reads of 0 return 0
        w0 = n_writes;
        wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
        tick();
        wb_valid = 0;
        tick();
        chk("t038_wb_ready_back", wb_ready, 1);
        chk("t038_no_write", n_writes - w0, 0);
        req_wait(0, 0, 0, 0, 0, 3, "lat_zero");
        chk("t038_rd0", {rs1_data, rs2_data}, 64'h0);
        release_rsp();
        tick();

        // Reset during READ2 drops the request and the buffered writeback
        rd_req_valid = 1; rs1 = 5; rs2 = 6;
        tick();
        rd_req_valid = 0;
        wb_valid = 1; wb_rd = 8; wb_data = 32'h55;
        tick();
        wb_valid = 0;
        chk("t039_in_read2", bank_select, 6);
        reset = 0;
        #1;
        chk_all_zero("t039_reset");
        model_clear();
        @(posedge clk);
        #1;
        reset = 1;
        #1;
        chk("t039_req_ready", rd_req_ready, 1);
        chk("t039_wb_ready", wb_ready, 1);
        w0 = n_writes;
        rd_rsp_ready = 1;
        repeat (6) tick();
        chk("t039_no_write", n_writes - w0, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rd_req_valid = ($urandom_range(0, 2) == 0);
            rs1 = SW'($urandom_range(0, 15));
            rs2 = SW'($urandom_range(0, 15));
            wb_valid = ($urandom_range(0, 3) == 0);
            wb_rd = SW'($urandom_range(0, 15));
            wb_data = $urandom;
            rd_rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regbank_port_sequencer.md
REGBANK_PORT_SEQUENCER -- requirements
Module: regbank_port_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, register data width; SEL_W, default 4, register index width (16 registers).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rd_req_valid / rd_req_ready  input / output  1 / 1  operand-read request handshake.
REQ-005 rs1, rs2  input  SEL_W each  source register indices, sampled on request fire.
REQ-006 rd_rsp_valid / rd_rsp_ready  output / input  1 / 1  operand response handshake.
REQ-007 rs1_data, rs2_data  output  DATA_W each  operand values, stable while rd_rsp_valid=1.
REQ-008 wb_valid / wb_ready  input / output  1 / 1  writeback request handshake.
REQ-009 wb_rd, wb_data  input  SEL_W / DATA_W  writeback index and value, sampled on wb fire.
REQ-010 bank_select  output  SEL_W  index to the single-port register bank.
REQ-011 bank_write  output  1  write enable to the bank.
REQ-012 bank_dataIn  output  DATA_W  write data to the bank.
REQ-013 bank_dataOut  input  DATA_W  bank read data, combinational from bank_select.

Function
REQ-014 Fire SHALL mean valid=1 and ready=1 in the same cycle.
REQ-015 FSM states SHALL be IDLE, WRITE, READ1, READ2, RESP.
REQ-016 Writeback buffer: one entry; wb_ready = not wb_full; wb fire latches wb_rd/wb_data and sets wb_full.
REQ-017 rd_req_ready SHALL be 1 only in IDLE with no latched request; fire latches rs1/rs2 and sets req_pending.
REQ-018 IDLE next state: WRITE if wb_full or wb fire; else READ1 if req_pending or request fire; else IDLE.
REQ-019 Simultaneous wb fire and request fire in IDLE SHALL perform WRITE before READ1 (write priority).
REQ-020 WRITE: bank_select=wb_rd, bank_dataIn=wb_data, bank_write=1 unless wb_rd=0; wb_full clears at cycle end; next READ1 if req_pending, else IDLE.
REQ-021 READ1: bank_select=rs1, bank_dataOut captured into rs1_data at cycle end; next READ2.
REQ-022 READ2: bank_select=rs2, capture into rs2_data; req_pending clears; next RESP.
REQ-023 Index 0 reads SHALL return 0 regardless of bank_dataOut.
REQ-024 RESP: rd_rsp_valid=1 until rd_rsp_ready=1; on fire next WRITE if wb_full, else IDLE.
REQ-025 bank_write SHALL be 0 and bank_dataIn 0 outside WRITE; bank_select 0 in IDLE and RESP.
REQ-026 Latency, no pending write: request fire cycle T -> rd_rsp_valid at T+3; with a write first, T+4.
REQ-027 A writeback accepted while READ1/READ2/RESP is active SHALL NOT affect that response; it is written after RESP completes.
REQ-028 rs1=rs2 SHALL be legal and read the register twice.
REQ-029 Writeback to index 0 SHALL complete the handshake and clear the buffer with no bank write.

Reset
REQ-030 reset low SHALL immediately force IDLE, clear wb_full and req_pending, zero rs1_data/rs2_data and latched fields.
REQ-031 While reset is low all outputs SHALL be 0, including rd_req_ready and wb_ready.
REQ-032 Reset mid-operation SHALL drop the in-flight request and any buffered writeback without a bank write.
REQ-033 After reset release, rd_req_ready=1 and wb_ready=1 in the first cycle.

Verification
REQ-034 wb_rd=5, wb_data=0xDEADBEEF, then request rs1=5, rs2=0 -> rs1_data=0xDEADBEEF, rs2_data=0.
REQ-035 Same-cycle wb fire (rd=3, 0x12345678) and request (rs1=3, rs2=3) in IDLE -> one write, then both operands 0x12345678, rsp at T+4.
REQ-036 Request rs1=7 accepted, then wb rd=7 0xAAAA5555 during READ1 -> response holds old value; bank write of 0xAAAA5555 follows RESP.
REQ-037 rd_rsp_ready held 0 for 5 cycles -> rd_rsp_valid and data stable; wb_ready drops after one buffered wb; no bank_write.
REQ-038 wb rd=0, data 0xFFFFFFFF -> wb_ready cycles, bank_write stays 0; later read of index 0 returns 0.
REQ-039 reset low during READ2 -> all outputs 0 at once; after release no response and no bank write occur.
